// File: rtl/mem_to_axi_bridge.sv
// Memory-port (req/gnt/rvalid) slave to single-beat AXI4+ATOP master bridge; optional error flag under MEM_TO_AXI_BRIDGE_ERR_EN.
// Latency: grant combinational on the AXI address/data handshake; mem_rvalid_o one cycle after the R/B handshake (>= 2 cycles after grant).
// Backpressure: mem_gnt_o withheld while AXI is not ready or MaxRequests are outstanding; R/B accepted only in grant order.

package mem_to_axi_bridge_pkg;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    axi_b_chan_t  b;
    logic         r_valid;
    axi_r_chan_t  r;
  } axi_rsp_t;
endpackage

// Generic synchronous FIFO used to remember the read/write order of granted requests.
// Latency: pushed entry visible at the head one cycle after the push.
// Backpressure: full/empty flags; a push while full is accepted only together with a pop.
module mem_to_axi_bridge_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] push_dat,
  input  logic             pop,
  output logic [Width-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  cnt;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Entry storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module mem_to_axi_bridge #(
  parameter type         axi_req_t   = mem_to_axi_bridge_pkg::axi_req_t,
  parameter type         axi_rsp_t   = mem_to_axi_bridge_pkg::axi_rsp_t,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AxiId       = 0,
  parameter int unsigned MaxRequests = 4,
  parameter logic [2:0]  AxProt      = 3'b000,
  parameter logic [3:0]  AxCache     = 4'b0010
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   busy_o,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  input  logic                   mem_we_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
  output logic                   mem_err_o,
`endif
  output axi_req_t               axi_req_o,
  input  axi_rsp_t               axi_rsp_i
);
  localparam int unsigned IdWidth = $bits(axi_req_o.aw.id);
  localparam logic [2:0]  AxSize  = 3'($clog2(DataWidth / 8));

  logic fifo_full, fifo_empty, fifo_head;
  logic aw_done, w_done;
  logic accept, ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic rd_gnt, wr_gnt, pop;
  logic [DataWidth-1:0] rdata_next;
  logic unused_rsp;

  // A request may only start when its response has a slot in the order FIFO
  assign accept   = mem_req_i && !fifo_full;
  assign ar_valid = accept && !mem_we_i;
  assign aw_valid = accept && mem_we_i && !aw_done;
  assign w_valid  = accept && mem_we_i && !w_done;

  assign ar_hs = ar_valid && axi_rsp_i.ar_ready;
  assign aw_hs = aw_valid && axi_rsp_i.aw_ready;
  assign w_hs  = w_valid  && axi_rsp_i.w_ready;

  // A write is granted once both AW and W have gone, in whichever order
  assign rd_gnt    = ar_hs;
  assign wr_gnt    = accept && mem_we_i && (aw_done || aw_hs) && (w_done || w_hs);
  assign mem_gnt_o = rd_gnt || wr_gnt;

  // Only the response channel matching the oldest request may be accepted
  assign r_ready = !fifo_empty && !fifo_head;
  assign b_ready = !fifo_empty &&  fifo_head;
  assign r_hs    = axi_rsp_i.r_valid && r_ready;
  assign b_hs    = axi_rsp_i.b_valid && b_ready;
  assign pop     = r_hs || b_hs;

  assign busy_o     = !fifo_empty || aw_done || w_done;
  assign unused_rsp = ^axi_rsp_i;

  mem_to_axi_bridge_fifo #(
    .Width (1),
    .Depth (MaxRequests)
  ) i_order_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (mem_gnt_o),
    .push_dat (mem_we_i),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Drive AXI request channels: constant attributes plus pass-through payload
  always_comb begin
    axi_req_o = '0;

    axi_req_o.aw.id    = IdWidth'(AxiId);
    axi_req_o.aw.addr  = mem_addr_i;
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw.cache = AxCache;
    axi_req_o.aw.prot  = AxProt;
    axi_req_o.aw_valid = aw_valid;

    axi_req_o.w.data   = mem_wdata_i;
    axi_req_o.w.strb   = mem_strb_i;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid;

    axi_req_o.ar.id    = IdWidth'(AxiId);
    axi_req_o.ar.addr  = mem_addr_i;
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar.cache = AxCache;
    axi_req_o.ar.prot  = AxProt;
    axi_req_o.ar_valid = ar_valid;

    axi_req_o.r_ready  = r_ready;
    axi_req_o.b_ready  = b_ready;
  end

  // Remember which half of a write has already handshaken until the grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_gnt) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
  // Read data returned only for non-error reads; writes always return zero
  always_comb begin
    rdata_next = '0;
    if (r_hs && !axi_rsp_i.r.resp[1]) rdata_next = axi_rsp_i.r.data;
  end

  // SLVERR and DECERR both have resp[1] set
  always_ff @(posedge clk_i) begin
    if (rst_i) mem_err_o <= 1'b0;
    else       mem_err_o <= (r_hs && axi_rsp_i.r.resp[1]) || (b_hs && axi_rsp_i.b.resp[1]);
  end
`else
  // Read data returned on R; writes return zero
  always_comb begin
    rdata_next = '0;
    if (r_hs) rdata_next = axi_rsp_i.r.data;
  end
`endif

  // Register the memory-side response one cycle after the AXI handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
    end else begin
      mem_rvalid_o <= pop;
      mem_rdata_o  <= rdata_next;
    end
  end
endmodule

// File: tb/tb_mem_to_axi_bridge.sv
// Scoreboard bench for mem_to_axi_bridge: directed scenarios then randomized traffic.
// A reactive AXI slave checks request payloads; a monitor checks memory responses in order.
// Expected read data and error codes are pure functions of the address.
`timescale 1ns/1ps
module tb_mem_to_axi_bridge;
  import mem_to_axi_bridge_pkg::*;

  localparam int MaxReq = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, mem_gnt, mem_rvalid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_strb;
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
  logic        mem_err;
`endif
  axi_req_t    axi_req;
  axi_rsp_t    axi_rsp;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_to_axi_bridge #(.MaxRequests(MaxReq)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .busy_o       (busy),
    .mem_req_i    (mem_req),
    .mem_gnt_o    (mem_gnt),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_strb_i   (mem_strb),
    .mem_we_i     (mem_we),
    .mem_rvalid_o (mem_rvalid),
    .mem_rdata_o  (mem_rdata),
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
    .mem_err_o    (mem_err),
`endif
    .axi_req_o    (axi_req),
    .axi_rsp_i    (axi_rsp)
  );

  int n_chk = 0, n_fail = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: slave data and response code depend only on the address
  function automatic logic [63:0] rd_word(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'h100;
    return 64'hDEADBEEF_CAFEF00D ^ {o, o * 32'h9E3779B9};
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return a[5:4];
  endfunction

  typedef struct {
    logic        we;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t predict(input logic we, input logic [31:0] a);
    exp_t        e;
    logic [1:0]  r;
    r    = resp_of(a);
    e.we = we;
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
    e.err  = r[1];
    e.data = (we || r[1]) ? 64'h0 : rd_word(a);
`else
    e.err  = 1'b0;
    e.data = we ? 64'h0 : rd_word(a);
`endif
    return e;
  endfunction

  // ---------------- AXI slave ----------------
  bit ready_all = 1, hold_r = 0, hold_b = 0, block_w = 0;
  logic [31:0] rd_q[$], aw_q[$];
  int w_pend = 0, aw_hs_cnt = 0;

  initial begin
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs, in_rst;
    axi_ar_chan_t ea;
    axi_aw_chan_t ew;
    axi_w_chan_t  ed;
    axi_rsp = '0;
    forever begin
      @(negedge clk);
      in_rst = rst;
      ar_hs = axi_req.ar_valid && axi_rsp.ar_ready;
      aw_hs = axi_req.aw_valid && axi_rsp.aw_ready;
      w_hs  = axi_req.w_valid  && axi_rsp.w_ready;
      r_hs  = axi_rsp.r_valid  && axi_req.r_ready;
      b_hs  = axi_rsp.b_valid  && axi_req.b_ready;
      if (in_rst) begin
        rd_q.delete(); aw_q.delete(); w_pend = 0;
      end else begin
        if (ar_hs) begin
          ea = '0; ea.addr = mem_addr; ea.size = 3'd3; ea.burst = 2'b01; ea.cache = 4'b0010;
          check("ar_fields", 128'(axi_req.ar), 128'(ea));
          check("ar_is_read", 128'(mem_we), 128'(0));
          rd_q.push_back(axi_req.ar.addr);
        end
        if (aw_hs) begin
          ew = '0; ew.addr = mem_addr; ew.size = 3'd3; ew.burst = 2'b01; ew.cache = 4'b0010;
          check("aw_fields", 128'(axi_req.aw), 128'(ew));
          check("aw_is_write", 128'(mem_we), 128'(1));
          aw_q.push_back(axi_req.aw.addr);
          aw_hs_cnt++;
        end
        if (w_hs) begin
          ed = '0; ed.data = mem_wdata; ed.strb = mem_strb; ed.last = 1'b1;
          check("w_fields", 128'(axi_req.w), 128'(ed));
          w_pend++;
        end
      end
      @(posedge clk);
      #1;
      if (in_rst) begin
        axi_rsp = '0;
      end else begin
        if (r_hs) begin void'(rd_q.pop_front()); axi_rsp.r_valid = 1'b0; end
        if (b_hs) begin void'(aw_q.pop_front()); w_pend--; axi_rsp.b_valid = 1'b0; end
        axi_rsp.ar_ready = ready_all || ($urandom_range(0, 3) != 0);
        axi_rsp.aw_ready = ready_all || ($urandom_range(0, 3) != 0);
        axi_rsp.w_ready  = !block_w && (ready_all || ($urandom_range(0, 3) != 0));
        if (!axi_rsp.r_valid && rd_q.size() > 0 && !hold_r && (ready_all || $urandom_range(0, 2) != 0)) begin
          axi_rsp.r_valid = 1'b1;
          axi_rsp.r.data  = rd_word(rd_q[0]);
          axi_rsp.r.resp  = resp_of(rd_q[0]);
          axi_rsp.r.last  = 1'b1;
        end
        if (!axi_rsp.b_valid && aw_q.size() > 0 && w_pend > 0 && !hold_b && (ready_all || $urandom_range(0, 2) != 0)) begin
          axi_rsp.b_valid = 1'b1;
          axi_rsp.b.resp  = resp_of(aw_q[0]);
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  int rv_cnt = 0, rv_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (!mem_req) check("gnt_without_req", 128'(mem_gnt), 128'(0));
        if (mem_rvalid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 128'(exp_q.size()), 128'(1));
          end else begin
            e = exp_q.pop_front();
            check(e.we ? "rsp_wr_rdata" : "rsp_rd_rdata", 128'(mem_rdata), 128'(e.data));
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
            check("rsp_err", 128'(mem_err), 128'(e.err));
`endif
          end
          rv_cnt++;
          rv_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int gnt_cyc = 0;

  task automatic do_req(input logic we, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bit got = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_strb = s;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (mem_gnt) begin
        got = 1;
        gnt_cyc = cyc;
        exp_q.push_back(predict(we, a));
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("gnt_timeout", 128'(got), 128'(1));
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n0, a0;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_gnt", 128'(mem_gnt), 128'(0));
    check("rst_rvalid", 128'(mem_rvalid), 128'(0));
    check("rst_rdata", 128'(mem_rdata), 128'(0));
    check("rst_valids", 128'({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid}), 128'(0));
    check("rst_readies", 128'({axi_req.r_ready, axi_req.b_ready}), 128'(0));
`ifdef MEM_TO_AXI_BRIDGE_ERR_EN
    check("rst_err", 128'(mem_err), 128'(0));
`endif
    @(posedge clk); #1;

    // single read, immediate AR ready: rvalid two cycles after grant
    do_req(1'b0, 32'h100, 64'h0, 8'h00);
    g = gnt_cyc;
    mem_req = 1'b0;
    drain();
    check("read_latency", 128'(rv_cyc - g), 128'(2));

    // single write, W ready three cycles after AW
    @(negedge clk); block_w = 1; @(posedge clk); #1;
    a0 = aw_hs_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 64'h11223344_55667788; mem_strb = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_gnt_early", 128'(mem_gnt), 128'(0));
      if (k > 0) check("wr_busy_half", 128'(busy), 128'(1));
      if (k == 2) block_w = 0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wr_gnt_on_w", 128'(mem_gnt), 128'(1));
    if (mem_gnt) exp_q.push_back(predict(1'b1, 32'h40));
    check("wr_aw_once", 128'(aw_hs_cnt - a0), 128'(1));
    @(posedge clk); #1;
    mem_req = 1'b0;
    drain();

    // six back-to-back reads with R held: only MaxReq granted
    @(negedge clk); hold_r = 1; @(posedge clk); #1;
    n0 = rv_cnt;
    for (int i = 0; i < MaxReq; i++) do_req(1'b0, 32'h200 + 32'(8 * i), 64'h0, 8'h00);
    mem_addr = 32'h220;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_no_gnt", 128'(mem_gnt), 128'(0));
      check("full_busy", 128'(busy), 128'(1));
      check("full_no_ar", 128'(axi_req.ar_valid), 128'(0));
      if (k == 3) hold_r = 0;
      @(posedge clk); #1;
    end
    do_req(1'b0, 32'h220, 64'h0, 8'h00);
    do_req(1'b0, 32'h228, 64'h0, 8'h00);
    mem_req = 1'b0;
    drain();
    check("six_rvalids", 128'(rv_cnt - n0), 128'(6));

    // write then read, B held while R is presented
    @(negedge clk); hold_b = 1; @(posedge clk); #1;
    do_req(1'b1, 32'h0, 64'hA5A5_0000_FFFF_1234, 8'hFF);
    do_req(1'b0, 32'h8, 64'h0, 8'h00);
    mem_req = 1'b0;
    n0 = rv_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("r_ready_blocked", 128'(axi_req.r_ready), 128'(0));
      if (k == 4) hold_b = 0;
      @(posedge clk); #1;
    end
    check("no_rsp_while_b_held", 128'(rv_cnt - n0), 128'(0));
    drain();

    // reset with two reads outstanding
    @(negedge clk); hold_r = 1; @(posedge clk); #1;
    do_req(1'b0, 32'h300, 64'h0, 8'h00);
    do_req(1'b0, 32'h308, 64'h0, 8'h00);
    mem_req = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 128'(busy), 128'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_gnt", 128'(mem_gnt), 128'(0));
    check("mid_rst_rvalid", 128'(mem_rvalid), 128'(0));
    hold_r = 0;
    @(posedge clk); #1;
    n0 = rv_cnt;
    do_req(1'b0, 32'h310, 64'h0, 8'h00);
    mem_req = 1'b0;
    drain();
    check("post_rst_one_rsp", 128'(rv_cnt - n0), 128'(1));

    // DECERR-coded read followed by an OKAY write
    do_req(1'b0, 32'h30, 64'h0, 8'h00);
    do_req(1'b1, 32'h0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    mem_req = 1'b0;
    drain();

    // randomized traffic with random AXI readiness
    @(negedge clk); ready_all = 0; @(posedge clk); #1;
    for (int i = 0; i < 80; i++) begin
      int idle;
      idle = $urandom_range(0, 2);
      if (idle > 0) begin
        mem_req = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
      end
      do_req(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom));
    end
    mem_req = 1'b0;
    drain();
    @(negedge clk);
    check("final_idle", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
